// File: rtl/mp_irq_scheduler.sv
// mp_irq_scheduler: shared-line interrupt scheduler for N_SOURCES event
// requesters. Rising edges on EVENT_IN set pending bits; unmasked pending
// sources are granted round robin, pulsed on IRQ_OUT for a programmable
// number of cycles and then held until the host acknowledges.
//
// Optional feature macro: MP_IRQ_SCHEDULER_RETRY_EN
//   defined   -> an unacknowledged IRQ is re-pulsed after the retry timeout
//   undefined -> WAIT_ACK waits indefinitely; RETRY_TIMEOUT is unused
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nothing in service; arbitrate among unmasked pending sources
// PULSE    | IRQ_OUT high for the granted source, duration counter running
// WAIT_ACK | pulse finished, waiting for IRQ_ACK (optionally timing out)
module mp_irq_scheduler #(
  parameter int N_SOURCES             = 4,
  parameter int DEFAULT_DURATION      = 100,
  parameter int DEFAULT_RETRY_TIMEOUT = 1000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_SOURCES-1:0] EVENT_IN,
  input  logic [N_SOURCES-1:0] MASK,
  input  logic [31:0]          DURATION,
  input  logic [31:0]          RETRY_TIMEOUT,
  input  logic                 IRQ_ACK,
  output logic                 IRQ_OUT,
  output logic [3:0]           IRQ_ID,
  output logic [N_SOURCES-1:0] PENDING,
  output logic                 BUSY
);

  localparam int              IW        = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
  localparam logic [31:0]     DEF_DUR   = 32'(DEFAULT_DURATION);
  localparam logic [31:0]     DEF_TO    = 32'(DEFAULT_RETRY_TIMEOUT);
  localparam logic [31:0]     CNT_MAX   = '1;
  localparam logic [IW-1:0]   LAST_INIT = IW'(N_SOURCES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [N_SOURCES-1:0]   event_q;
  logic [N_SOURCES-1:0]   pending;
  logic [N_SOURCES-1:0]   rise;
  logic [N_SOURCES-1:0]   eligible;
  logic [N_SOURCES-1:0]   clr_mask;
  logic [IW-1:0]          irq_id;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          grant_idx;
  logic                   grant_valid;
  logic                   ack_accept;
  logic [31:0]            dur_cnt;
  logic [31:0]            deff;
  int                     cand;

`ifdef MP_IRQ_SCHEDULER_RETRY_EN
  logic [31:0]            to_cnt;
  logic [31:0]            teff;
  assign teff = (RETRY_TIMEOUT == '0) ? DEF_TO : RETRY_TIMEOUT;
`else
  logic                   unused_retry;
  assign unused_retry = ^{RETRY_TIMEOUT, DEF_TO};
`endif

  // Counters stop at all-ones rather than wrapping back to a small value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  assign rise       = EVENT_IN & ~event_q;
  assign eligible   = pending & ~MASK;
  assign deff       = (DURATION == '0) ? DEF_DUR : DURATION;
  assign ack_accept = IRQ_ACK && ((state == PULSE) || (state == WAIT_ACK));
  assign PENDING    = pending;
  assign IRQ_ID     = 4'(irq_id);

  // Round-robin pick: first eligible source at or above last_grant+1, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < N_SOURCES; i++) begin
      cand = int'(last_grant) + 1 + i;
      if (cand >= N_SOURCES) cand = cand - N_SOURCES;
      if (!grant_valid && eligible[IW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Pending bit of the serviced source is dropped on an accepted ack.
  always_comb begin
    clr_mask = '0;
    if (ack_accept) clr_mask[irq_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; ack takes precedence over pulse/timeout expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_valid) state_next = PULSE;
      end
      PULSE: begin
        if (IRQ_ACK)                          state_next = IDLE;
        else if (dur_cnt == deff - 32'd1)     state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (IRQ_ACK)                          state_next = IDLE;
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
        else if (to_cnt == teff - 32'd1)      state_next = PULSE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    IRQ_OUT = (state == PULSE);
    BUSY    = (state != IDLE);
  end

  // Event sampling, pending bits, grant bookkeeping and cycle counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      event_q    <= '0;
      pending    <= '0;
      irq_id     <= '0;
      last_grant <= LAST_INIT;
      dur_cnt    <= '0;
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
      to_cnt     <= '0;
`endif
    end else begin
      event_q <= EVENT_IN;
      // A new edge on the source being acked re-arms it (set wins).
      pending <= (pending & ~clr_mask) | rise;
      if (ack_accept) last_grant <= irq_id;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            irq_id  <= grant_idx;
            dur_cnt <= '0;
          end
        end
        PULSE: begin
          if (state_next == PULSE) dur_cnt <= sat_inc(dur_cnt);
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
          else if (state_next == WAIT_ACK) to_cnt <= '0;
`endif
        end
        WAIT_ACK: begin
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
          if (state_next == PULSE)         dur_cnt <= '0;
          else if (state_next == WAIT_ACK) to_cnt  <= sat_inc(to_cnt);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_irq_scheduler.sv
// tb_mp_irq_scheduler: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_mp_irq_scheduler;
  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  EVENT_IN = '0;
  logic [3:0]  MASK = '0;
  logic [31:0] DURATION = 32'd5;
  logic [31:0] RETRY_TIMEOUT = 32'd10;
  logic        IRQ_ACK = 1'b0;
  logic        IRQ_OUT;
  logic [3:0]  IRQ_ID;
  logic [3:0]  PENDING;
  logic        BUSY;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: phase 0 idle, 1 pulsing, 2 waiting for ack.
  int         m_phase = 0;
  int         m_id    = 0;
  int         m_last  = N - 1;
  int         m_el    = 0;
  int         m_wel   = 0;
  logic [3:0] m_pend  = '0;
  logic [3:0] m_prev  = '0;

  mp_irq_scheduler #(
    .N_SOURCES(N),
    .DEFAULT_DURATION(100),
    .DEFAULT_RETRY_TIMEOUT(1000)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .EVENT_IN(EVENT_IN),
    .MASK(MASK),
    .DURATION(DURATION),
    .RETRY_TIMEOUT(RETRY_TIMEOUT),
    .IRQ_ACK(IRQ_ACK),
    .IRQ_OUT(IRQ_OUT),
    .IRQ_ID(IRQ_ID),
    .PENDING(PENDING),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock of the scheduler's rules, applied to the inputs seen at the edge.
  task automatic model_update();
    logic [3:0] rise;
    logic [3:0] nxt;
    logic [3:0] elig;
    int         deff;
    int         teff;
    bit         ack;
    bit         found;
    if (RESET) begin
      m_phase = 0; m_id = 0; m_last = N - 1; m_el = 0; m_wel = 0;
      m_pend = '0; m_prev = '0;
    end else begin
      rise = EVENT_IN & ~m_prev;
      deff = (DURATION == 0) ? 100 : int'(DURATION);
      teff = (RETRY_TIMEOUT == 0) ? 1000 : int'(RETRY_TIMEOUT);
      ack  = IRQ_ACK && (m_phase != 0);
      nxt  = m_pend;
      if (ack) nxt[m_id[1:0]] = 1'b0;
      nxt = nxt | rise;
      case (m_phase)
        0: begin
          elig  = m_pend & ~MASK;
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && elig[c[1:0]]) begin
              found = 1'b1;
              m_id  = c;
            end
          end
          if (found) begin m_phase = 1; m_el = 0; end
        end
        1: begin
          if (ack) begin m_last = m_id; m_phase = 0; end
          else if (m_el + 1 == deff) begin m_phase = 2; m_wel = 0; end
          else m_el++;
        end
        default: begin
          if (ack) begin m_last = m_id; m_phase = 0; end
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
          else if (m_wel + 1 == teff) begin m_phase = 1; m_el = 0; end
          else m_wel++;
`endif
        end
      endcase
      m_pend = nxt;
      m_prev = EVENT_IN;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    cyc++;
    chk("irq_out", 32'(IRQ_OUT), 32'(m_phase == 1));
    chk("busy",    32'(BUSY),    32'(m_phase != 0));
    chk("irq_id",  32'(IRQ_ID),  32'(m_id));
    chk("pending", 32'(PENDING), 32'(m_pend));
  endtask

  task automatic ack_now();
    IRQ_ACK = 1'b1;
    step();
    IRQ_ACK = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int k = 0; k < 300; k++) begin
      if (IRQ_OUT) begin
        id = int'(IRQ_ID);
        break;
      end
      step();
    end
  endtask

  task automatic measure_pulse(output int len);
    int seen;
    len = 0;
    wait_grant(seen);
    if (seen >= 0) begin
      while (IRQ_OUT && len < 400) begin
        len++;
        step();
      end
    end
  endtask

  initial begin
    int id;
    int hi;
    int len;
    logic exp_irq;

    // Reset state
    step();
    step();
    RESET = 1'b0;
    chk("rst_irq_out", 32'(IRQ_OUT), 32'd0);
    chk("rst_irq_id",  32'(IRQ_ID),  32'd0);
    chk("rst_pending", 32'(PENDING), 32'd0);
    chk("rst_busy",    32'(BUSY),    32'd0);

    // Single edge, DURATION=5: latency, pulse length, ack
    DURATION = 32'd5;
    EVENT_IN = 4'b0100;
    step();
    chk("lat_pending", 32'(PENDING), 32'h4);
    chk("lat_irq_low", 32'(IRQ_OUT), 32'd0);
    step();
    chk("lat_irq_high", 32'(IRQ_OUT), 32'd1);
    chk("lat_id",       32'(IRQ_ID),  32'd2);
    hi = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (IRQ_OUT) hi++;
    end
    chk("dur5_len", 32'(hi), 32'd5);
    ack_now();
    chk("ack_pending", 32'(PENDING), 32'd0);
    chk("ack_busy",    32'(BUSY),    32'd0);

    // Round robin 0,1,3 then re-edge on 0
    do_reset();
    EVENT_IN = 4'b0000;
    step();
    EVENT_IN = 4'b1011;
    wait_grant(id); chk("rr_first",  32'(id), 32'd0); ack_now();
    wait_grant(id); chk("rr_second", 32'(id), 32'd1); ack_now();
    wait_grant(id); chk("rr_third",  32'(id), 32'd3); ack_now();
    EVENT_IN = 4'b1010;
    step();
    EVENT_IN = 4'b1011;
    wait_grant(id); chk("rr_reedge", 32'(id), 32'd0); ack_now();

    // Mask holds source 0 back until cleared
    EVENT_IN = 4'b0000;
    MASK     = 4'b0001;
    step();
    EVENT_IN = 4'b0011;
    wait_grant(id); chk("mask_first", 32'(id), 32'd1); ack_now();
    repeat (4) step();
    chk("mask_hold_busy", 32'(BUSY),    32'd0);
    chk("mask_hold_pend", 32'(PENDING), 32'h1);
    MASK = 4'b0000;
    wait_grant(id); chk("mask_released", 32'(id), 32'd0); ack_now();

    // No ack: retry behaviour (or a single pulse without the retry feature)
    do_reset();
    DURATION      = 32'd3;
    RETRY_TIMEOUT = 32'd10;
    EVENT_IN      = 4'b0000;
    step();
    EVENT_IN = 4'b0100;
    wait_grant(id);
    chk("retry_id", 32'(id), 32'd2);
    for (int k = 0; k < 40; k++) begin
`ifdef MP_IRQ_SCHEDULER_RETRY_EN
      exp_irq = ((k % 13) < 3);
`else
      exp_irq = (k < 3);
`endif
      chk("retry_shape", 32'(IRQ_OUT), 32'(exp_irq));
      step();
    end
    chk("retry_busy",  32'(BUSY),   32'd1);
    chk("retry_id_hold", 32'(IRQ_ID), 32'd2);
    ack_now();
    chk("retry_done", 32'(BUSY), 32'd0);

    // DURATION=0 selects the 100-cycle default
    DURATION = 32'd0;
    EVENT_IN = 4'b0000;
    step();
    EVENT_IN = 4'b0001;
    measure_pulse(len);
    chk("dur0_len", 32'(len), 32'd100);
    ack_now();

    // Ack coinciding with a new edge on the same source
    DURATION = 32'd4;
    EVENT_IN = 4'b0010;
    step();
    EVENT_IN = 4'b0000;
    wait_grant(id);
    chk("coin_grant", 32'(id), 32'd1);
    EVENT_IN = 4'b0010;
    ack_now();
    chk("coin_pending", 32'(PENDING), 32'h2);
    wait_grant(id);
    chk("coin_reserve", 32'(id), 32'd1);
    ack_now();

    // Reset in the middle of a pulse
    EVENT_IN = 4'b0000;
    step();
    EVENT_IN = 4'b1000;
    wait_grant(id);
    chk("midrst_grant", 32'(id), 32'd3);
    step();
    RESET = 1'b1;
    step();
    chk("midrst_irq",  32'(IRQ_OUT), 32'd0);
    chk("midrst_pend", 32'(PENDING), 32'd0);
    chk("midrst_busy", 32'(BUSY),    32'd0);
    RESET = 1'b0;

    // Randomized traffic against the model
    for (int seg = 0; seg < 10; seg++) begin
      DURATION      = 32'($urandom_range(1, 6));
      RETRY_TIMEOUT = 32'($urandom_range(1, 8));
      for (int c = 0; c < 200; c++) begin
        EVENT_IN = EVENT_IN ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
        if ($urandom_range(0, 19) == 0) MASK = 4'($urandom);
        IRQ_ACK = ($urandom_range(0, 5) == 0);
        RESET   = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    RESET   = 1'b0;
    IRQ_ACK = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
